song_reader: RTL



---
 rtl/song_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/song_reader.sv
// song_reader: playback sequencer for the music player.
//
// Walks a song held in a synchronous-read note memory, one entry per note,
// and presents each note code to the tone generator for its programmed
// duration (dur ticks of TICK_DIV clock cycles each). An entry whose duration
// field is 0 marks the end of the song. Playback also ends after the last
// memory address has been played. The address never wraps.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   start      begin playback from address 0 (sampled only in IDLE)
//   stop       abort playback and return to IDLE (no done pulse)
//   mem_addr   note memory read address
//   mem_data   memory read data {note, dur}, valid one cycle after mem_addr
//   note       current note code to the tone generator (0 = rest)
//   note_valid high while a note is being played
//   playing    high in FETCH, LOAD and PLAY
//   done       one-cycle pulse at the normal end of the song
module song_reader #(
  parameter int ADDR_W   = 5,
  parameter int NOTE_W   = 8,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [NOTE_W+DUR_W-1:0] mem_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    note_valid,
  output logic                    playing,
  output logic                    done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [NOTE_W-1:0]   note_next;
  logic [DUR_W-1:0]    dur_cnt, dur_next;
  logic [TICK_W-1:0]   tick_cnt, tick_next;

  logic [NOTE_W-1:0]   mem_note;
  logic [DUR_W-1:0]    mem_dur;

  assign mem_note = mem_data[NOTE_W+DUR_W-1:DUR_W];
  assign mem_dur  = mem_data[DUR_W-1:0];

  // Status outputs decode the state register directly, so an asynchronous
  // reset clears them immediately along with the state.
  assign note_valid = (state == PLAY);
  assign playing    = (state == FETCH) || (state == LOAD) || (state == PLAY);
  assign done       = (state == DONE);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    addr_next  = mem_addr;
    note_next  = note;
    dur_next   = dur_cnt;
    tick_next  = tick_cnt;

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = FETCH;
          addr_next  = '0;
        end
      end

      // Address is presented; the memory returns data during LOAD.
      FETCH: state_next = LOAD;

      LOAD: begin
        if (mem_dur == '0) begin
          state_next = DONE;
          note_next  = '0;
        end else begin
          state_next = PLAY;
          note_next  = mem_note;
          dur_next   = mem_dur;
          tick_next  = '0;
        end
      end

      PLAY: begin
        if (tick_cnt == TICK_LAST) begin
          tick_next = '0;
          dur_next  = dur_cnt - DUR_W'(1);
          if (dur_cnt == DUR_W'(1)) begin
            note_next = '0;
            if (mem_addr == ADDR_LAST) begin
              state_next = DONE;
            end else begin
              state_next = FETCH;
              addr_next  = mem_addr + ADDR_W'(1);
            end
          end
        end else begin
          tick_next = tick_cnt + TICK_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
        addr_next  = '0;
      end

      default: state_next = IDLE;
    endcase

    // Abort overrides every transition above, including end-of-note and
    // the end marker, and never produces a done pulse.
    if (stop && ((state == FETCH) || (state == LOAD) || (state == PLAY))) begin
      state_next = IDLE;
      addr_next  = '0;
      note_next  = '0;
      dur_next   = '0;
      tick_next  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      note     <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_next;
      mem_addr <= addr_next;
      note     <= note_next;
      dur_cnt  <= dur_next;
      tick_cnt <= tick_next;
    end
  end

endmodule
